// File: rtl/cache_line_fill_ctrl_if.sv
// Bus bundle for the single-line cache fill controller.
// Groups the CPU read port, the main-memory byte fetch handshake,
// the line storage port and the hit/miss statistics.
// The master modport is the controller's view; the slave modport is
// the environment's view (CPU, memory and storage together).
interface cache_line_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) ();

  // CPU read port
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic [7:0]        cpu_data;
  logic              flush;

  // Main-memory byte fetch
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;

  // Line storage port
  logic [7:0]        cache_data;
  logic [4:0]        cache_wroffset;
  logic              cache_wren;
  logic [4:0]        cache_rdoffset;
  logic [7:0]        cache_q;

  // Statistics
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    input  cpu_req, cpu_addr, flush, mem_ack, mem_data, cache_q,
    output cpu_ready, cpu_data, mem_req, mem_addr,
           cache_data, cache_wroffset, cache_wren, cache_rdoffset,
           hit_count, miss_count
  );

  modport slave (
    output cpu_req, cpu_addr, flush, mem_ack, mem_data, cache_q,
    input  cpu_ready, cpu_data, mem_req, mem_addr,
           cache_data, cache_wroffset, cache_wren, cache_rdoffset,
           hit_count, miss_count
  );

endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Controller for a single 32-byte cache line.
// A CPU byte read is checked against the resident tag; on a miss the
// whole line is fetched from memory one byte per req/ack beat, in
// offset order 0..31, and written straight into the storage port.
// Once resident, the byte is read from storage and returned with a
// one-cycle ready pulse. Hits and misses are counted with saturation.
module cache_line_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cache_line_fill_ctrl_if.master  bus
);

  localparam int TAG_W = ADDR_W - 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_FILL   = 3'd2,
    S_READ   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [TAG_W-1:0]  tag_q,       tag_d;
  logic              valid_q,     valid_d;
  logic [4:0]        beat_q,      beat_d;
  logic [4:0]        rdoff_q,     rdoff_d;
  logic [7:0]        cpu_data_q,  cpu_data_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              mem_req_q,   mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [CNT_W-1:0]  hit_q,       hit_d;
  logic [CNT_W-1:0]  miss_q,      miss_d;

  logic              hit_s;
  logic              fill_ack_s;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign hit_s      = valid_q && (tag_q == addr_q[ADDR_W-1:5]);
  // A memory beat completes only while filling; stray acks elsewhere are ignored.
  assign fill_ack_s = (state_q == S_FILL) && bus.mem_ack;

  // Next-state and datapath decisions for the lookup/fill/respond sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    beat_d      = beat_q;
    rdoff_d     = rdoff_q;
    cpu_data_d  = cpu_data_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    cpu_ready_d = 1'b0;
    mem_req_d   = 1'b0;
    mem_addr_d  = {ADDR_W{1'b0}};

    case (state_q)
      S_IDLE: begin
        // A request takes priority; a simultaneous flush is dropped.
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          rdoff_d = bus.cpu_addr[4:0];
          state_d = S_LOOKUP;
        end else if (bus.flush) begin
          valid_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOOKUP: begin
        if (hit_s) begin
          hit_d   = sat_inc(hit_q);
          state_d = S_READ;
        end else begin
          // Invalidate up front so an aborted fill never leaves a stale valid line.
          miss_d  = sat_inc(miss_q);
          valid_d = 1'b0;
          beat_d  = 5'd0;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        if (fill_ack_s) begin
          beat_d = beat_q + 5'd1;
          if (beat_q == 5'd31) begin
            tag_d   = addr_q[ADDR_W-1:5];
            valid_d = 1'b1;
            state_d = S_READ;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end

      S_READ: begin
        // Storage output has had one full cycle to settle on rdoffset.
        cpu_data_d = bus.cache_q;
        state_d    = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output registers follow the state being entered so they line up with it.
    if (state_d == S_RESP) begin
      cpu_ready_d = 1'b1;
    end else begin
      cpu_ready_d = 1'b0;
    end

    if (state_d == S_FILL) begin
      mem_req_d  = 1'b1;
      mem_addr_d = {addr_d[ADDR_W-1:5], beat_d};
    end else begin
      mem_req_d  = 1'b0;
      mem_addr_d = {ADDR_W{1'b0}};
    end
  end

  // State, line metadata, statistics and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      tag_q       <= {TAG_W{1'b0}};
      valid_q     <= 1'b0;
      beat_q      <= 5'd0;
      rdoff_q     <= 5'd0;
      cpu_data_q  <= 8'd0;
      cpu_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      hit_q       <= {CNT_W{1'b0}};
      miss_q      <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      beat_q      <= beat_d;
      rdoff_q     <= rdoff_d;
      cpu_data_q  <= cpu_data_d;
      cpu_ready_q <= cpu_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  // The storage write must land in the same cycle as the memory ack,
  // so the write strobe and data are a direct function of the ack.
  assign bus.cache_wren     = fill_ack_s;
  assign bus.cache_data     = fill_ack_s ? bus.mem_data : 8'd0;
  assign bus.cache_wroffset = beat_q;

  assign bus.cache_rdoffset = rdoff_q;
  assign bus.cpu_ready      = cpu_ready_q;
  assign bus.cpu_data       = cpu_data_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.hit_count      = hit_q;
  assign bus.miss_count     = miss_q;

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Directed + randomized bench for cache_line_fill_ctrl. A memory responder
// with random ack delays, a 32-byte storage model and a line-level reference
// model (valid/tag/counters) predict every response, latency and fill.
module tb_cache_line_fill_ctrl;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 3;   // small so saturation is reached
  localparam int CMAX   = 7;

  logic clk;
  logic rst_n;

  cache_line_fill_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  cache_line_fill_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the line at a behavioural level
  bit        m_valid = 1'b0;
  logic [10:0] m_tag = 11'd0;
  int        m_hits  = 0;
  int        m_miss  = 0;

  // Environment state
  int          max_delay  = 0;
  int          fill_total = 0;
  int          wait_cnt   = 0;
  logic [15:0] ack_addr_q[$];
  logic [4:0]  wr_off_q[$];
  logic [7:0]  wr_data_q[$];
  logic [7:0]  stor[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mbyte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks each beat after 0..max_delay extra cycles.
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'd0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack  = 1'b0;
      bus.mem_data = 8'($urandom);
      if (bus.mem_req === 1'b1) begin
        fill_total++;
        if (wait_cnt == 0) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = mbyte(bus.mem_addr);
          ack_addr_q.push_back(bus.mem_addr);
          wait_cnt = $urandom_range(max_delay, 0);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Storage model: writes on the falling edge, records every write.
  always @(negedge clk) begin
    if (bus.cache_wren === 1'b1) begin
      stor[bus.cache_wroffset] = bus.cache_data;
      wr_off_q.push_back(bus.cache_wroffset);
      wr_data_q.push_back(bus.cache_data);
    end
  end

  // Storage read data follows rdoffset one cycle later.
  always @(posedge clk) begin
    bus.cache_q <= stor[bus.cache_rdoffset];
  end

  // mode 0: noise on cpu_req/flush while busy; 1: flush with the request;
  // 2: flush held high for the whole transaction.
  task automatic do_read(input logic [15:0] addr, input int mode);
    bit exp_hit;
    int cyc, a0, w0, f0, na, nw, nchk;
    exp_hit = m_valid && (m_tag == addr[15:5]);
    a0 = ack_addr_q.size();
    w0 = wr_off_q.size();
    @(posedge clk); #1;
    f0 = fill_total;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    bus.flush    = (mode == 1);
    @(posedge clk); #1;
    cyc = 1;
    while (bus.cpu_ready !== 1'b1 && cyc < 400) begin
      bus.cpu_req  = 1'($urandom);
      bus.cpu_addr = 16'($urandom);
      bus.flush    = (mode == 2) ? 1'b1 : 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    bus.cpu_req = 1'b0;
    bus.flush   = 1'b0;
    chk("ready_seen", {31'd0, bus.cpu_ready}, 32'd1);
    chk("cpu_data", {24'd0, bus.cpu_data}, {24'd0, mbyte(addr)});
    chk("latency", cyc + 1, 4 + (fill_total - f0));
    na = ack_addr_q.size() - a0;
    nw = wr_off_q.size() - w0;
    chk("beats", na, exp_hit ? 0 : 32);
    chk("writes", nw, exp_hit ? 0 : 32);
    nchk = (na < nw) ? na : nw;
    if (nchk > 32) nchk = 32;
    for (int i = 0; i < nchk; i++) begin
      chk("mem_addr", {16'd0, ack_addr_q[a0 + i]}, {16'd0, addr[15:5], 5'(i)});
      chk("wroffset", {27'd0, wr_off_q[w0 + i]}, i);
      chk("wrdata", {24'd0, wr_data_q[w0 + i]}, {24'd0, mbyte({addr[15:5], 5'(i)})});
    end
    if (exp_hit) begin
      if (m_hits < CMAX) m_hits++;
    end else begin
      if (m_miss < CMAX) m_miss++;
      m_valid = 1'b1;
      m_tag   = addr[15:5];
    end
    chk("hit_count", {29'd0, bus.hit_count}, m_hits);
    chk("miss_count", {29'd0, bus.miss_count}, m_miss);
    @(posedge clk); #1;
    chk("ready_pulse", {31'd0, bus.cpu_ready}, 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.cpu_ready}, 32'd0);
    chk({tag, "_data"}, {24'd0, bus.cpu_data}, 32'd0);
    chk({tag, "_mreq"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_maddr"}, {16'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_wren"}, {31'd0, bus.cache_wren}, 32'd0);
    chk({tag, "_rdoff"}, {27'd0, bus.cache_rdoffset}, 32'd0);
    chk({tag, "_wroff"}, {27'd0, bus.cache_wroffset}, 32'd0);
    chk({tag, "_hits"}, {29'd0, bus.hit_count}, 32'd0);
    chk({tag, "_miss"}, {29'd0, bus.miss_count}, 32'd0);
  endtask

  initial begin
    int cyc;
    logic [15:0] ra;
    rst_n        = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 16'd0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss with zero-delay memory, then hits at both line ends
    max_delay = 0;
    do_read(16'h0123, 0);
    do_read(16'h0120, 0);
    do_read(16'h013F, 0);

    // New tag evicts; old line then misses again
    do_read(16'h0240, 0);
    do_read(16'h0123, 0);

    // Random memory latency
    max_delay = 3;
    do_read(16'h0240, 0);
    do_read(16'h025F, 0);

    // Flush in IDLE forces a miss
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    m_valid = 1'b0;
    do_read(16'h0240, 0);

    // Flush held during a fill is ignored
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    m_valid = 1'b0;
    do_read(16'h0247, 2);
    do_read(16'h0255, 0);

    // Request and flush together: request wins, line stays valid
    do_read(16'h0241, 1);
    do_read(16'h0242, 0);

    // Random reads over a few lines
    for (int k = 0; k < 10; k++) begin
      ra = {3'd0, 6'($urandom_range(3, 0)), 2'd0, 5'($urandom)};
      do_read(ra, int'($urandom_range(2, 0)));
    end

    // Reset in the middle of a fill
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    m_valid = 1'b0;
    begin
      int w0;
      w0 = wr_off_q.size();
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 16'h0123;
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      cyc = 0;
      while ((wr_off_q.size() - w0) < 10 && cyc < 400) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("mid_fill_reached", wr_off_q.size() - w0, 10);
    end
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    m_valid = 1'b0;
    m_hits  = 0;
    m_miss  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(16'h0123, 0);
    do_read(16'h0130, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
